// File: rtl/button_conditioner_if.sv
// Push-button bundle between the raw button pads and the lock FSM.
// Carries the three raw button levels into the conditioner, and carries the
// conditioned key pulses, the debounced levels and the chord-conflict flag out.
//   master : drives the raw levels and observes the conditioned outputs
//            (the pad side, or a testbench).
//   slave  : the conditioner itself.
interface button_conditioner_if;
  logic reset_raw;
  logic zero_raw;
  logic one_raw;
  logic reset_pulse;
  logic zero_pulse;
  logic one_pulse;
  logic zero_level;
  logic one_level;
  logic conflict;

  modport master (
    output reset_raw, zero_raw, one_raw,
    input  reset_pulse, zero_pulse, one_pulse, zero_level, one_level, conflict
  );

  modport slave (
    input  reset_raw, zero_raw, one_raw,
    output reset_pulse, zero_pulse, one_pulse, zero_level, one_level, conflict
  );
endinterface

// File: rtl/button_conditioner.sv
// Button front end for the combination-lock FSM.
// Each raw button level (reset, zero, one) goes through a two-flop
// synchroniser and a counting debouncer. Every debounced rising edge becomes
// a registered one-cycle key pulse. A zero/one press made while the other
// key is also held is dropped and reported on conflict instead.
//   clk : system clock, rising edge
//   clr : synchronous active-high reset, overrides everything
//   btn : slave side of button_conditioner_if
//         in : reset_raw, zero_raw, one_raw
//         out: reset_pulse, zero_pulse, one_pulse, zero_level, one_level,
//              conflict
// DEBOUNCE_CYCLES (1..65535) is the number of consecutive synchronised
// cycles an input must disagree with its debounced level before the level
// follows it.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 clr,
  button_conditioner_if.slave  btn
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Channel index into the per-button vectors
  localparam int CH_RST  = 0;
  localparam int CH_ZERO = 1;
  localparam int CH_ONE  = 2;

  logic [2:0]            raw_vec;
  logic [2:0]            sync1;
  logic [2:0]            sync2;
  logic [2:0]            lvl;
  logic [2:0]            lvl_nxt;
  logic [2:0]            rise;
  logic [2:0][CNT_W-1:0] cnt;
  logic [2:0][CNT_W-1:0] cnt_nxt;

  logic reset_pulse_q;
  logic zero_pulse_q;
  logic one_pulse_q;
  logic conflict_q;

  logic reset_pulse_d;
  logic zero_pulse_d;
  logic one_pulse_d;
  logic conflict_d;

  assign raw_vec = {btn.one_raw, btn.zero_raw, btn.reset_raw};

  // Debounce: count consecutive disagreeing samples; any agreeing sample
  // (a bounce back) restarts the count. The level flips on the sample that
  // would complete DEBOUNCE_CYCLES disagreements.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      lvl_nxt[i] = lvl[i];
      cnt_nxt[i] = '0;
      if (sync2[i] != lvl[i]) begin
        if (cnt[i] == CNT_LAST) begin
          lvl_nxt[i] = sync2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_ONE;
        end
      end
    end
  end

  assign rise = lvl_nxt & ~lvl;

  // Qualification looks at the levels as they will be after this edge, so a
  // key that rises while the other key is already (or simultaneously) down
  // is a chord. A reset press masks any key or conflict event on the same edge.
  always_comb begin
    reset_pulse_d = rise[CH_RST];
    zero_pulse_d  = rise[CH_ZERO] & ~lvl_nxt[CH_ONE]  & ~rise[CH_RST];
    one_pulse_d   = rise[CH_ONE]  & ~lvl_nxt[CH_ZERO] & ~rise[CH_RST];
    conflict_d    = (rise[CH_ZERO] | rise[CH_ONE]) &
                    lvl_nxt[CH_ZERO] & lvl_nxt[CH_ONE] & ~rise[CH_RST];
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      sync1         <= '0;
      sync2         <= '0;
      lvl           <= '0;
      cnt           <= '0;
      reset_pulse_q <= 1'b0;
      zero_pulse_q  <= 1'b0;
      one_pulse_q   <= 1'b0;
      conflict_q    <= 1'b0;
    end else begin
      sync1         <= raw_vec;
      sync2         <= sync1;
      lvl           <= lvl_nxt;
      cnt           <= cnt_nxt;
      reset_pulse_q <= reset_pulse_d;
      zero_pulse_q  <= zero_pulse_d;
      one_pulse_q   <= one_pulse_d;
      conflict_q    <= conflict_d;
    end
  end

  assign btn.reset_pulse = reset_pulse_q;
  assign btn.zero_pulse  = zero_pulse_q;
  assign btn.one_pulse   = one_pulse_q;
  assign btn.conflict    = conflict_q;
  assign btn.zero_level  = lvl[CH_ZERO];
  assign btn.one_level   = lvl[CH_ONE];

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Front-end stage that sits directly upstream of the combination-lock FSM.
- Takes the three raw, asynchronous push-button levels (reset, zero, one) and synchronises each to clk.
- Debounces each channel and emits clean single-cycle press pulses that the lock FSM consumes as its key events.
- Detects chorded zero/one presses, drops them, and flags them on a conflict output, so the lock never sees an ambiguous key.

Parameters:
- DEBOUNCE_CYCLES, default 4: consecutive clk cycles a synchronised input must differ from its debounced level before that level flips. Legal range is 1 to 65535. Counter width is $clog2(DEBOUNCE_CYCLES+1), derived internally.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- clr  input  1  synchronous, active-high reset.
- reset_raw  input  1  raw RESET push-button level; asynchronous; may bounce.
- zero_raw  input  1  raw ZERO push-button level; asynchronous; may bounce.
- one_raw  input  1  raw ONE push-button level; asynchronous; may bounce.
- reset_pulse  output  1  one-cycle pulse on a debounced RESET press.
- zero_pulse  output  1  one-cycle pulse on a qualified debounced ZERO press.
- one_pulse  output  1  one-cycle pulse on a qualified debounced ONE press.
- zero_level  output  1  debounced ZERO level.
- one_level  output  1  debounced ONE level.
- conflict  output  1  one-cycle pulse when a zero/one press is dropped because both buttons are held.

Behaviour:
- Reset is fixed: one clock; reset is synchronous and active-high. The clock port is clk and the reset port is clr.
- While clr=1 at a clk edge, the following are all forced to 0:
  - both synchroniser flops of every channel;
  - all debounce counters;
  - all debounced levels;
  - every output.
- clr has priority over all other activity, including a debounce in progress; a count in progress is discarded.
- Synchroniser: each raw input passes through two flops, s1 then s2. No logic sits between them.
- Debounce, per channel, with a counter cnt and a stable level lvl:
  - s2 == lvl: cnt <= 0.
  - s2 != lvl and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - s2 != lvl and cnt == DEBOUNCE_CYCLES-1: lvl <= s2 and cnt <= 0.
- A bounce, meaning s2 returning to lvl, restarts the count. Any excursion shorter than DEBOUNCE_CYCLES synchronised cycles is invisible.
- Rise event: lvl goes 0->1 at a given edge. Release (1->0) produces no pulse.
- Pulses are registered outputs, asserted for exactly the one cycle after the edge where lvl rises.
- Latency: a raw input that goes high before edge E0 and stays clean gives lvl=1 and a pulse in the cycle after edge E(DEBOUNCE_CYCLES+1). With the default that is 6 edges.
- reset_pulse = reset rise. It is never gated.
- Qualification of zero/one, evaluated on the post-update levels at that edge:
  - zero_pulse = zero rise AND next one_lvl == 0 AND NOT reset rise.
  - one_pulse = one rise AND next zero_lvl == 0 AND NOT reset rise.
  - conflict = (zero rise OR one rise) AND next zero_lvl AND next one_lvl AND NOT reset rise.
- Invariant: zero_pulse and one_pulse are never both 1 in the same cycle.
- Simultaneous rises of zero and one at the same edge produce conflict=1 and no key pulse.
- Reset rise in the same cycle as a zero/one rise: only reset_pulse asserts; the key rise and the conflict are dropped.
- Holding a button produces exactly one pulse; re-pressing requires a debounced release first.
- zero_level and one_level equal their lvl flops with no added latency.
- A button held through a clr release is treated as a new press: pulse after DEBOUNCE_CYCLES+2 edges, counting from the first edge with clr=0.

Test Plan:
- Clean press: DEBOUNCE_CYCLES=4, zero_raw 0->1 before edge E0, held 20 cycles -> zero_pulse=1 only in the cycle after E5. zero_level=1 from then on. No one_pulse, no conflict.
- Bounce rejection: one_raw toggled high for 3 cycles, low 1, high 2, low, repeated for 30 cycles -> one_pulse never asserts and one_level stays 0. Then hold one_raw high -> exactly one one_pulse, 6 edges after the last low-to-high transition.
- Chord: zero_raw held high and debounced, then one_raw raised -> conflict=1 for one cycle, one_pulse=0. Zero's earlier pulse occurred exactly once.
- Simultaneous: zero_raw and one_raw rise before the same edge -> conflict=1 for one cycle; zero_pulse=0 and one_pulse=0 throughout.
- Reset priority: reset_raw and zero_raw rise before the same edge -> reset_pulse=1 for one cycle, while zero_pulse=0 and conflict=0.
- clr mid-debounce: zero_raw high, clr=1 at edge E3, clr=0 afterwards, raw still high -> all outputs 0 during clr. zero_pulse fires in the cycle after the 6th edge with clr=0.
